button_arbiter: RTL and testbench
=================================

BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 Parameter NUM_BUTTONS, default 14, number of raw button inputs.
REQ-002 Parameter DEBOUNCE_TICKS, default 4, consecutive stable tick samples required to accept a press or a release (legal range 1..255).
REQ-003 clk_i  input  1  system clock; all logic SHALL be on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 tick_i  input  1  single-cycle sample strobe (1 kHz enable from the clock divider).
REQ-006 buttons_i  input  NUM_BUTTONS  raw, asynchronous button levels, bit i = button i.
REQ-007 button_ready_i  input  1  calculator accepts the presented button this cycle.
REQ-008 button_valid_o  output  1  debounced single-button press event pending.
REQ-009 button_idx_o  output  $clog2(NUM_BUTTONS)  index of pressed button, meaningful when button_valid_o=1.
REQ-010 multi_press_o  output  1  one-cycle pulse when an ambiguous multi-button press is discarded.
REQ-011 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 buttons_i SHALL pass through a 2-flop synchronizer (sync_q); all decisions use sync_q sampled on cycles with tick_i=1 only.
REQ-013 FSM states SHALL be IDLE, PRESS_DB, ISSUE, HELD; state, pattern register and counter change only on tick_i=1, except ISSUE exit, which is handshake-driven.
REQ-014 IDLE: on tick with sync_q!=0 -> PRESS_DB, pattern_q<=sync_q, cnt<=1; sync_q==0 -> stay.
REQ-015 PRESS_DB on tick: sync_q==0 -> IDLE; sync_q!=pattern_q -> pattern_q<=sync_q, cnt<=1; sync_q==pattern_q -> cnt<=cnt+1.
REQ-016 When cnt reaches DEBOUNCE_TICKS (including DEBOUNCE_TICKS=1 on the entry tick): exactly one bit set -> ISSUE; more than one bit set -> HELD with multi_press_o=1 for exactly one cycle.
REQ-017 ISSUE: button_valid_o=1, button_idx_o=index of the single set bit of pattern_q; both held stable, independent of tick_i and buttons_i, until button_valid_o && button_ready_i.
REQ-018 Handshake: transfer occurs on a cycle with valid&&ready; the next cycle SHALL have button_valid_o=0 and state HELD, cnt<=0; button_ready_i while valid=0 SHALL be ignored.
REQ-019 HELD on tick: sync_q!=0 -> cnt<=0; sync_q==0 -> cnt<=cnt+1; on cnt reaching DEBOUNCE_TICKS -> IDLE.
REQ-020 A button held indefinitely SHALL yield exactly one event (no auto-repeat); a new event requires a debounced all-release first.
REQ-021 Additional buttons pressed during ISSUE or HELD SHALL neither alter button_idx_o nor create events.
REQ-022 Latency: with a clean press stable before the tick, button_valid_o rises the clock after the DEBOUNCE_TICKS-th consecutive tick seeing the pattern.
REQ-023 Counter width SHALL be $clog2(DEBOUNCE_TICKS+1); counter SHALL saturate and never wrap.
REQ-024 button_idx_o SHALL be 0 when button_valid_o=0.
REQ-025 busy_o SHALL be combinational from state (state != IDLE).

Reset
REQ-026 rst_ni=0 SHALL immediately force state=IDLE, sync flops, pattern_q and cnt to 0, button_valid_o=0, button_idx_o=0, multi_press_o=0, busy_o=0, including mid-ISSUE with an unaccepted event, which is discarded.
REQ-027 After reset release, a button already held SHALL be treated as a new press (debounced from IDLE).

Verification
REQ-028 Hold buttons_i=14'h0020, ready=1, DEBOUNCE_TICKS=4 -> one valid cycle, idx=5, after the 4th tick; no further event while held.
REQ-029 Press bit 3 with 1-tick glitch to 0 at tick 2 -> return to IDLE, no event; clean re-press -> idx=3.
REQ-030 Hold 14'h0041 for 4 ticks -> multi_press_o one-cycle pulse, no valid; release 4 ticks -> busy_o=0.
REQ-031 Press bit 13 with ready=0 for 50 cycles -> valid and idx=13 stable throughout; ready=1 -> accepted, valid=0 next cycle.
REQ-032 Assert rst_ni=0 during ISSUE -> valid=0 asynchronously; release with bit 2 held -> new event idx=2 after 4 ticks.
REQ-033 500 random iterations (0/1/2 buttons, 1 tick each) vs reference model -> event count and indices match exactly, never two events without an intervening debounced release.

Source files
------------

// File: rtl/button_arbiter.sv
// Debounces a bank of raw buttons and issues one ready/valid event per clean single-button press.
// Multi-button presses are discarded with a one-cycle flag; a debounced full release re-arms.
module button_arbiter #(
  parameter int unsigned NUM_BUTTONS    = 14,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           tick_i,
  input  logic [NUM_BUTTONS-1:0]         buttons_i,
  input  logic                           button_ready_i,
  output logic                           button_valid_o,
  output logic [$clog2(NUM_BUTTONS)-1:0] button_idx_o,
  output logic                           multi_press_o,
  output logic                           busy_o
);

  localparam int unsigned IdxW = $clog2(NUM_BUTTONS);
  localparam int unsigned CntW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {StIdle, StPressDb, StIssue, StHeld} state_e;

  state_e                 state_q, state_d;
  logic [NUM_BUTTONS-1:0] sync1_q, sync_q;
  logic [NUM_BUTTONS-1:0] pattern_q, pattern_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                   multi_q, multi_d;
  logic                   db_step;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      state_q   <= StIdle;
      pattern_q <= '0;
      cnt_q     <= '0;
      multi_q   <= 1'b0;
    end else begin
      sync1_q   <= buttons_i;
      sync_q    <= sync1_q;
      state_q   <= state_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      multi_q   <= multi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    multi_d   = 1'b0;
    db_step   = 1'b0;
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (tick_i && (sync_q != '0)) begin
          state_d   = StPressDb;
          pattern_d = sync_q;
          cnt_d     = CntW'(1);
          db_step   = 1'b1;
        end
      end
      StPressDb: begin
        if (tick_i) begin
          if (sync_q == '0) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            db_step = 1'b1;
            if (sync_q != pattern_q) begin
              pattern_d = sync_q;
              cnt_d     = CntW'(1);
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end
      StIssue: begin
        if (button_ready_i) begin
          state_d = StHeld;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        if (tick_i) begin
          if (sync_q != '0) begin
            cnt_d = '0;
          end else if (cnt_inc == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
    endcase

    // Settle decision also covers the entry tick so DEBOUNCE_TICKS=1 works.
    if (db_step && (cnt_d == CntMax)) begin
      if ((pattern_d & (pattern_d - NUM_BUTTONS'(1))) == '0) begin
        state_d = StIssue;
      end else begin
        state_d = StHeld;
        cnt_d   = '0;
        multi_d = 1'b1;
      end
    end
  end

  always_comb begin
    button_idx_o = '0;
    if (state_q == StIssue) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (pattern_q[i]) button_idx_o = IdxW'(i);
      end
    end
  end

  assign button_valid_o = (state_q == StIssue);
  assign multi_press_o  = multi_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_button_arbiter.sv
// Directed and model-checked stimulus for button_arbiter with 14 buttons, 4-tick debounce.
module tb_button_arbiter;

  localparam int unsigned NB = 14;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic [NB-1:0] buttons;
  logic          ready;
  logic          valid;
  logic [3:0]    idx;
  logic          multi;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  button_arbiter #(.NUM_BUTTONS(NB), .DEBOUNCE_TICKS(D)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick),
    .buttons_i     (buttons),
    .button_ready_i(ready),
    .button_valid_o(valid),
    .button_idx_o  (idx),
    .multi_press_o (multi),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event / pulse monitor
  int ev_count = 0;
  int last_idx = -1;
  int obs_q[$];
  int mp_count = 0;
  int mp_long  = 0;
  int viol     = 0;
  bit armed    = 1'b1;
  bit multi_prev = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        ev_count++;
        last_idx = int'(idx);
        obs_q.push_back(int'(idx));
        if (!armed) viol++;
        armed = 1'b0;
      end
      if (!busy) armed = 1'b1;
      if (multi) mp_count++;
      if (multi && multi_prev) mp_long++;
      multi_prev = multi;
    end else begin
      armed = 1'b1;
      multi_prev = 1'b0;
    end
  end

  task automatic do_tick();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  // Tick-level reference model (ready held high, so an event never waits across a tick)
  typedef enum int {MIdle, MDeb, MHeld} mstate_e;
  mstate_e m_state = MIdle;
  logic [NB-1:0] m_pat = '0;
  int m_n   = 0;
  int m_rel = 0;
  int exp_q[$];
  int m_multi = 0;

  task automatic model_tick(input logic [NB-1:0] s);
    bit settle = 1'b0;
    case (m_state)
      MIdle: if (s != 0) begin m_state = MDeb; m_pat = s; m_n = 1; settle = 1'b1; end
      MDeb: begin
        if (s == 0) m_state = MIdle;
        else begin
          if (s != m_pat) begin m_pat = s; m_n = 1; end
          else m_n++;
          settle = 1'b1;
        end
      end
      MHeld: begin
        if (s != 0) m_rel = 0;
        else m_rel++;
        if (m_rel == D) m_state = MIdle;
      end
      default: m_state = MIdle;
    endcase
    if (settle && m_n == D) begin
      m_state = MHeld;
      m_rel = 0;
      if ($countones(m_pat) == 1) begin
        for (int b = 0; b < NB; b++) if (m_pat[b]) exp_q.push_back(b);
      end else begin
        m_multi++;
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int mp_base;
    int nmin;
    logic [NB-1:0] p;

    rst_n = 1'b0; tick = 1'b0; buttons = '0; ready = 1'b0;
    #1;
    check("reset_valid", valid, 0);
    check("reset_idx", idx, 0);
    check("reset_multi", multi, 0);
    check("reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single press, held indefinitely
    ready = 1'b1;
    buttons = 14'h0020;
    ticks(3);
    check("press5_before_4th_valid", valid, 0);
    check("press5_debounce_busy", busy, 1);
    do_tick();
    check("press5_valid", valid, 1);
    check("press5_idx", idx, 5);
    @(negedge clk);
    check("press5_valid_drop", valid, 0);
    check("press5_held_busy", busy, 1);
    check("press5_idx_zero", idx, 0);
    ticks(10);
    check("press5_no_repeat", ev_count, 1);
    buttons = '0;
    ticks(3);
    check("press5_release_partial", busy, 1);
    do_tick();
    check("press5_release_idle", busy, 0);

    // Glitch during debounce, then clean press
    buttons = 14'h0008;
    do_tick();
    buttons = '0;
    do_tick();
    check("glitch_idle", busy, 0);
    buttons = 14'h0008;
    ticks(4);
    @(negedge clk);
    check("glitch_event_count", ev_count, 2);
    check("glitch_idx", last_idx, 3);
    buttons = '0;
    ticks(4);

    // Two buttons at once
    mp_base = mp_count;
    buttons = 14'h0041;
    ticks(4);
    check("multi_pulse", multi, 1);
    check("multi_no_valid", valid, 0);
    @(negedge clk);
    check("multi_pulse_end", multi, 0);
    check("multi_count", mp_count - mp_base, 1);
    check("multi_no_event", ev_count, 2);
    buttons = '0;
    ticks(4);
    check("multi_release_idle", busy, 0);

    // Backpressure: event must stay stable while extra buttons come and go
    ready = 1'b0;
    buttons = 14'h2000;
    ticks(4);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      buttons = (k % 3 == 0) ? 14'h2001 : ((k % 3 == 1) ? 14'h0000 : 14'h2000);
      do_tick();
      if (valid !== 1'b1 || idx !== 4'd13) bad++;
    end
    repeat (4) begin
      @(negedge clk);
      if (valid !== 1'b1 || idx !== 4'd13) bad++;
    end
    check("stall_stable_cycles_bad", bad, 0);
    check("stall_no_transfer", ev_count, 2);
    ready = 1'b1;
    @(negedge clk);
    check("stall_accept_valid_drop", valid, 0);
    check("stall_accept_count", ev_count, 3);
    check("stall_accept_idx", last_idx, 13);
    buttons = '0;
    ticks(4);
    check("stall_release_idle", busy, 0);

    // Reset in the middle of an unaccepted event
    ready = 1'b0;
    buttons = 14'h0004;
    ticks(4);
    check("rst_pre_valid", valid, 1);
    check("rst_pre_idx", idx, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_idx", idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    ticks(3);
    check("rst_repress_early", valid, 0);
    do_tick();
    check("rst_repress_valid", valid, 1);
    check("rst_repress_idx", idx, 2);
    @(negedge clk);
    check("rst_repress_count", ev_count, 4);
    buttons = '0;
    ticks(4);
    check("rst_release_idle", busy, 0);

    // Random 0/1/2-button patterns against the model
    obs_q.delete();
    mp_base = mp_count;
    p = '0;
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: p = '0;
          1: p = NB'(1) << $urandom_range(0, NB - 1);
          default: begin
            int a, b;
            a = $urandom_range(0, NB - 1);
            b = (a + $urandom_range(1, NB - 1)) % NB;
            p = (NB'(1) << a) | (NB'(1) << b);
          end
        endcase
      end
      buttons = p;
      do_tick();
      model_tick(p);
    end
    buttons = '0;
    for (int k = 0; k < D; k++) begin
      do_tick();
      model_tick('0);
    end
    repeat (3) @(negedge clk);
    check("rand_event_count", obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    bad = 0;
    for (int k = 0; k < nmin; k++) if (obs_q[k] != exp_q[k]) bad++;
    check("rand_idx_mismatches", bad, 0);
    check("rand_multi_count", mp_count - mp_base, m_multi);
    check("rand_final_idle", busy, 0);
    check("no_event_without_release", viol, 0);
    check("multi_pulse_single_cycle", mp_long, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
